// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared widths and controller state encoding for the SRAM
//                client port. Client masters (BIST and others) import the
//                address/data widths from here.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Controller sequencing: power-up wait, then accept client traffic forever.
  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sat_counter
//  Description : Debug event counter that counts up on each cycle with inc
//                high and sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
//
//  Ports
//    Clock   in   system clock, posedge
//    Resetn  in   asynchronous active-low reset, clears the count
//    inc     in   count enable for this cycle
//    value   out  current count (CNT_WIDTH bits)
// ============================================================================
module sram_sat_counter #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] r_value;
  logic                 w_at_max;

  assign w_at_max = &r_value;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_value <= '0;
    end else if (inc && !w_at_max) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/sram_interface_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_interface_ctrl
//  Description : Responder end of the SRAM client port. Waits INIT_CYCLES
//                after reset with the chip disabled, then registers client
//                address / write data / write strobe onto the asynchronous
//                SRAM pins, drives the data bus during writes and returns
//                read data two cycles after the client presents an address.
//                Completed reads and writes are counted for debug.
//  Revision    : 1.0 - initial release
//
//  Ports
//    Clock             in    system clock, posedge
//    Resetn            in    asynchronous active-low reset
//    SRAM_address      in    client word address
//    SRAM_write_data   in    client write data
//    SRAM_we_n         in    client write strobe, active low (high = read)
//    SRAM_read_data    out   captured read data
//    SRAM_ready        out   high once power-up wait is over
//    SRAM_read_count   out   saturating count of read captures
//    SRAM_write_count  out   saturating count of write cycles
//    SRAM_DQ           inout external data bus
//    SRAM_ADDRESS      out   external address pins
//    SRAM_UB_N/LB_N    out   byte enables, active low
//    SRAM_WE_N         out   external write enable, active low
//    SRAM_CE_N         out   chip enable, active low
//    SRAM_OE_N         out   output enable, active low
// ============================================================================
module sram_interface_ctrl
  import sram_pkg::*;
#(
  parameter int INIT_CYCLES = 16,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic [SRAM_ADDR_W-1:0] SRAM_address,
  input  logic [SRAM_DATA_W-1:0] SRAM_write_data,
  input  logic                   SRAM_we_n,
  output logic [SRAM_DATA_W-1:0] SRAM_read_data,
  output logic                   SRAM_ready,
  output logic [CNT_WIDTH-1:0]   SRAM_read_count,
  output logic [CNT_WIDTH-1:0]   SRAM_write_count,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDRESS,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int c_init_w = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYCLES - 1);

  ctrl_state_t            r_state;
  ctrl_state_t            w_state_nxt;
  logic [c_init_w-1:0]    r_init_cnt;

  logic [SRAM_ADDR_W-1:0] r_addr;
  logic                   r_we_n;
  logic [SRAM_DATA_W-1:0] r_wdata;
  logic                   r_dq_oe;
  logic [SRAM_DATA_W-1:0] r_rdata;

  logic                   w_active;
  logic                   w_ready;
  logic                   w_ce_n;
  logic                   w_oe_n;
  logic                   w_ub_n;
  logic                   w_lb_n;
  logic                   w_rd_capture;
  logic                   w_wr_done;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. S_READY is terminal; only reset returns to S_INIT.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == c_init_last) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. OE_N stays low while ready: the SRAM itself disables its
  // outputs whenever WE_N is low, so writes never fight the array.
  // --------------------------------------------------------------------------
  always_comb begin
    w_active = 1'b0;
    w_ready  = 1'b0;
    w_ce_n   = 1'b1;
    w_oe_n   = 1'b1;
    w_ub_n   = 1'b1;
    w_lb_n   = 1'b1;
    case (r_state)
      S_READY: begin
        w_active = 1'b1;
        w_ready  = 1'b1;
        w_ce_n   = 1'b0;
        w_oe_n   = 1'b0;
        w_ub_n   = 1'b0;
        w_lb_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // Power-up wait counter; parks at its last value once the wait is over.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_init_cnt <= '0;
    end else if (r_state == S_INIT && r_init_cnt != c_init_last) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: client request onto the pins. Address, WE_N and bus drive all
  // move on the same edge, so read/write turnaround needs no idle cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_addr  <= '0;
      r_we_n  <= 1'b1;
      r_wdata <= '0;
      r_dq_oe <= 1'b0;
    end else if (w_active) begin
      r_addr  <= SRAM_address;
      r_we_n  <= SRAM_we_n;
      r_wdata <= SRAM_write_data;
      r_dq_oe <= ~SRAM_we_n;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: sample the bus one cycle after a read was put on the pins.
  // --------------------------------------------------------------------------
  assign w_rd_capture = w_active &  r_we_n;
  assign w_wr_done    = w_active & ~r_we_n;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_rdata <= '0;
    end else if (w_rd_capture) begin
      r_rdata <= SRAM_DQ;
    end
  end

  assign SRAM_DQ = r_dq_oe ? r_wdata : {SRAM_DATA_W{1'bz}};

  sram_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_read_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (w_rd_capture),
    .value  (SRAM_read_count)
  );

  sram_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_write_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (w_wr_done),
    .value  (SRAM_write_count)
  );

  assign SRAM_read_data = r_rdata;
  assign SRAM_ready     = w_ready;
  assign SRAM_ADDRESS   = r_addr;
  assign SRAM_WE_N      = r_we_n;
  assign SRAM_CE_N      = w_ce_n;
  assign SRAM_OE_N      = w_oe_n;
  assign SRAM_UB_N      = w_ub_n;
  assign SRAM_LB_N      = w_lb_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_interface_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_interface_ctrl
//  Description : Directed self-checking bench for sram_interface_ctrl with a
//                behavioural asynchronous SRAM on the pins. A second instance
//                (INIT_CYCLES=1, CNT_WIDTH=4) covers the shortest power-up
//                wait and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_interface_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        rst2_n;
  logic [17:0] cl_addr;
  logic [15:0] cl_wdata;
  logic        cl_we_n;

  logic [15:0] read_data;
  logic        ready;
  logic [23:0] read_count;
  logic [23:0] write_count;
  wire  [15:0] dq;
  logic [17:0] pin_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  logic [15:0] read_data2;
  logic        ready2;
  logic [3:0]  read_count2;
  logic [3:0]  write_count2;
  wire  [15:0] dq2;
  logic [17:0] pin_addr2;
  logic        ub_n2, lb_n2, we_n2, ce_n2, oe_n2;

  int n_checks = 0;
  int n_errors = 0;

  sram_interface_ctrl #(
    .INIT_CYCLES (16),
    .CNT_WIDTH   (24)
  ) dut (
    .Clock            (Clock),
    .Resetn           (Resetn),
    .SRAM_address     (cl_addr),
    .SRAM_write_data  (cl_wdata),
    .SRAM_we_n        (cl_we_n),
    .SRAM_read_data   (read_data),
    .SRAM_ready       (ready),
    .SRAM_read_count  (read_count),
    .SRAM_write_count (write_count),
    .SRAM_DQ          (dq),
    .SRAM_ADDRESS     (pin_addr),
    .SRAM_UB_N        (ub_n),
    .SRAM_LB_N        (lb_n),
    .SRAM_WE_N        (we_n),
    .SRAM_CE_N        (ce_n),
    .SRAM_OE_N        (oe_n)
  );

  sram_interface_ctrl #(
    .INIT_CYCLES (1),
    .CNT_WIDTH   (4)
  ) dut2 (
    .Clock            (Clock),
    .Resetn           (rst2_n),
    .SRAM_address     (18'h00000),
    .SRAM_write_data  (16'h0000),
    .SRAM_we_n        (1'b1),
    .SRAM_read_data   (read_data2),
    .SRAM_ready       (ready2),
    .SRAM_read_count  (read_count2),
    .SRAM_write_count (write_count2),
    .SRAM_DQ          (dq2),
    .SRAM_ADDRESS     (pin_addr2),
    .SRAM_UB_N        (ub_n2),
    .SRAM_LB_N        (lb_n2),
    .SRAM_WE_N        (we_n2),
    .SRAM_CE_N        (ce_n2),
    .SRAM_OE_N        (oe_n2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural asynchronous SRAM ----------------
  function automatic logic [15:0] pre(input logic [17:0] a);
    return a[15:0] ^ 16'h6C00;
  endfunction

  logic [15:0] mem [0:262143];
  logic        mem_init = 1'b0;
  logic        model_oe;
  logic [15:0] model_data;

  assign model_oe   = !ce_n && !oe_n && we_n;
  assign model_data = mem[pin_addr];
  assign dq         = model_oe ? model_data : 16'hzzzz;

  always @(posedge Clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 262144; i++) mem[i] <= pre(18'(i));
      mem_init <= 1'b1;
    end else if (!ce_n && !we_n) begin
      mem[pin_addr] <= dq;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic client(input logic w_n, input logic [17:0] a,
                        input logic [15:0] d);
    cl_we_n  = w_n;
    cl_addr  = a;
    cl_wdata = d;
    tick();
  endtask

  // Count edges until ready rises; also flag the chip being enabled early.
  task automatic wait_ready(input string tag);
    int n;
    int ce_bad;
    n = 0;
    ce_bad = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (!ready && (ce_n !== 1'b1 || we_n !== 1'b1)) ce_bad++;
    end
    check_value({tag, "_cycles"}, n, 16);
    check_value({tag, "_ce_en_early"}, ce_bad, 0);
    check_value({tag, "_ce_n_ready"}, {31'd0, ce_n}, 0);
  endtask

  int          rc0, wc0;

  initial begin
    Resetn   = 1'b0;
    rst2_n   = 1'b0;
    // A write attempt held through reset and init must never execute.
    cl_we_n  = 1'b0;
    cl_addr  = 18'h00005;
    cl_wdata = 16'hDEAD;
    repeat (3) tick();

    check_value("rst_ready", {31'd0, ready}, 0);
    check_value("rst_pins", {27'd0, we_n, ce_n, oe_n, ub_n, lb_n}, 32'h1F);
    check_value("rst_addr", {14'd0, pin_addr}, 0);
    check_value("rst_rdata", {16'd0, read_data}, 0);
    check_value("rst_counts", {read_count[15:0], write_count[15:0]}, 0);

    Resetn = 1'b1;
    rst2_n = 1'b1;
    check_value("init1_not_ready", {31'd0, ready2}, 0);
    tick();
    check_value("init1_ready", {31'd0, ready2}, 1);
    begin
      int n;
      int ce_bad;
      n = 1;
      ce_bad = 0;
      while (!ready && n < 100) begin
        tick();
        n++;
        if (!ready && (ce_n !== 1'b1 || we_n !== 1'b1)) ce_bad++;
      end
      check_value("init_cycles", n, 16);
      check_value("init_ce_en_early", ce_bad, 0);
      check_value("init_ce_n_ready", {31'd0, ce_n}, 0);
    end

    // Discarded init write: address 5 still holds its preloaded value.
    cl_we_n = 1'b1;
    repeat (3) tick();
    check_value("init_discard_data", {16'd0, read_data}, {16'd0, pre(18'h5)});
    check_value("init_discard_wc", write_count, 0);

    // Single write then immediate read of the same address.
    client(1'b0, 18'h00010, 16'hA5A5);
    client(1'b1, 18'h00010, 16'h0000);
    check_value("rd_we_pin", {31'd0, we_n}, 1);
    check_value("rd_lat_early", {16'd0, read_data}, {16'd0, pre(18'h5)});
    tick();
    check_value("rd_after_wr", {16'd0, read_data}, 32'hA5A5);

    // Burst write 0..7 then burst read 0..7.
    wc0 = int'(write_count);
    for (int i = 0; i < 8; i++) client(1'b0, 18'(i), 16'(i));
    rc0 = int'(read_count);
    for (int j = 0; j < 8; j++) begin
      client(1'b1, 18'(j), 16'h0000);
      if (j >= 1)
        check_value($sformatf("burst_rd%0d", j - 1), {16'd0, read_data}, j - 1);
    end
    tick();
    check_value("burst_rd7", {16'd0, read_data}, 7);
    check_value("burst_read_count", read_count, 24'(rc0 + 8));
    check_value("burst_write_count", write_count, 24'(wc0 + 8));

    // Alternating write/read every cycle, top address included.
    client(1'b0, 18'h3FFFF, 16'hFFFF);
    client(1'b1, 18'h3FFFF, 16'h0000);
    client(1'b0, 18'h00000, 16'h1234);
    check_value("alt_rd_top", {16'd0, read_data}, 32'hFFFF);
    client(1'b1, 18'h00000, 16'h0000);
    tick();
    check_value("alt_rd_zero", {16'd0, read_data}, 32'h1234);

    // Reset in the middle of a write burst.
    client(1'b0, 18'h00100, 16'hBEEF);
    client(1'b0, 18'h00101, 16'hCAFE);
    check_value("mid_we_before", {31'd0, we_n}, 0);
    Resetn = 1'b0;
    #1;
    check_value("mid_we_n", {31'd0, we_n}, 1);
    check_value("mid_ce_n", {31'd0, ce_n}, 1);
    check_value("mid_ready", {31'd0, ready}, 0);
    check_value("mid_rcount", read_count, 0);
    check_value("mid_wcount", write_count, 0);
    cl_we_n = 1'b1;
    cl_addr = 18'h00100;
    repeat (2) tick();
    Resetn = 1'b1;
    wait_ready("reinit");
    client(1'b1, 18'h00100, 16'h0000);
    tick();
    check_value("mid_kept_write", {16'd0, read_data}, 32'hBEEF);
    client(1'b1, 18'h00101, 16'h0000);
    tick();
    check_value("mid_lost_write", {16'd0, read_data}, {16'd0, pre(18'h101)});

    // Second instance has been idling (reading) far longer than 15 cycles.
    check_value("sat_read_count", {28'd0, read_count2}, 15);
    check_value("sat_write_count", {28'd0, write_count2}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sram_interface_ctrl.md
Name: sram_interface_ctrl

Overview:
- Responder end of the 18-bit address / 16-bit data SRAM client port driven by the BIST engine and other client masters.
- Registers client address, write data and write strobe onto the external asynchronous SRAM pins and drives the bidirectional data bus during writes.
- Captures read data from the pins and returns it to the client with a fixed 2-cycle latency.
- Sequences SRAM power-up before accepting traffic and counts completed accesses for debug.

Parameters:
- INIT_CYCLES, 16, cycles after reset with chip disabled before SRAM_ready asserts; must be at least 1.
- CNT_WIDTH, 24, width of read/write access counters; counters saturate.

Ports:
- Clock  input  1  system clock, all logic on posedge
- Resetn  input  1  asynchronous active-low reset
- SRAM_address  input  18  client word address
- SRAM_write_data  input  16  client write data
- SRAM_we_n  input  1  client write strobe, active low; high = read
- SRAM_read_data  output  16  read data, valid 2 cycles after address presented
- SRAM_ready  output  1  high once init done; client traffic ignored while low
- SRAM_read_count  output  CNT_WIDTH  completed read captures
- SRAM_write_count  output  CNT_WIDTH  completed write cycles
- SRAM_DQ  inout  16  external SRAM data bus
- SRAM_ADDRESS  output  18  external address pins
- SRAM_UB_N  output  1  upper byte enable, active low
- SRAM_LB_N  output  1  lower byte enable, active low
- SRAM_WE_N  output  1  external write enable, active low
- SRAM_CE_N  output  1  chip enable, active low
- SRAM_OE_N  output  1  output enable, active low

Behaviour:
- Reset values (asynchronous): state=S_INIT; init counter=0; SRAM_ADDRESS=0; SRAM_WE_N=1; SRAM_CE_N=1; SRAM_OE_N=1; SRAM_UB_N=1; SRAM_LB_N=1.
- Reset values, continued: internal write-data reg=0; DQ drive enable=0 (SRAM_DQ high-Z); SRAM_read_data=0; SRAM_ready=0; both counters=0.
- FSM S_INIT: init counter increments each cycle. When it reaches INIT_CYCLES-1, go to S_READY, set SRAM_ready=1, and drive CE_N=OE_N=UB_N=LB_N=0.
- FSM S_READY: stays indefinitely; only reset leaves it. Pins are held at their reset values throughout S_INIT.
- Pipeline stage 1 (S_READY only): at each posedge, SRAM_ADDRESS<=SRAM_address, SRAM_WE_N<=SRAM_we_n, write-data reg<=SRAM_write_data, DQ drive enable<=~SRAM_we_n.
- SRAM_DQ = drive enable ? write-data reg : high-Z.
- SRAM_OE_N is held at 0 in S_READY; the SRAM disables its outputs when WE_N=0, so there is no bus contention.
- Read/write turnaround needs no idle cycle. Drive enable and WE_N change on the same edge as the address.
- Pipeline stage 2: at each posedge in S_READY, SRAM_read_data<=SRAM_DQ when registered SRAM_WE_N==1; otherwise SRAM_read_data holds its value.
- Latency: client presents address A at edge k. Pins update at edge k+1, and SRAM_read_data holds mem[A] after edge k+2. Back-to-back reads give one word per cycle.
- Write latency: data is written into the SRAM during the cycle following edge k+1. A read of the same address issued on the next client cycle returns the new data.
- Counters: SRAM_read_count +1 on each stage-2 capture; SRAM_write_count +1 on each cycle with registered SRAM_WE_N==0. Both saturate at all-ones and do not wrap.
- Client inputs in S_INIT are ignored and not queued. Nothing presented before SRAM_ready is ever executed.
- Address wrap is the client's responsibility: 18'h3FFFF is legal, and no increment is performed here.
- Reset mid-write: asynchronous reset releases DQ to high-Z and raises WE_N immediately; the in-flight write is lost. After reset the controller re-enters S_INIT and waits INIT_CYCLES again.

Decomposition:
- Shared package sram_pkg: SRAM_ADDR_W=18, SRAM_DATA_W=16, controller state enum {S_INIT, S_READY}.
- BIST and other clients import the package widths.
- One sub-module: sram_sat_counter (CNT_WIDTH, inc, value), instantiated twice for the counters.
- Tristate assignment stays at the top level.

Test Plan:
- Reset release, INIT_CYCLES=16 -> SRAM_ready=0, CE_N=1, DQ high-Z for exactly 16 cycles, then SRAM_ready=1, CE_N=0.
- Write 16'hA5A5 to 18'h00010, then read 18'h00010 on the next cycle -> SRAM_read_data=16'hA5A5 exactly 2 edges after the read address; DQ high-Z during the read.
- Burst write addr N data N[15:0] for N=0..7, then burst read 0..7 -> read_data sequence 0..7 with one word per cycle, 2-cycle lag; read_count=8, write_count=8.
- Alternating write/read every cycle (W 18'h3FFFF=16'hFFFF, R 18'h3FFFF, W 0=16'h1234, R 0) -> no DQ contention (model flags X), reads return 16'hFFFF then 16'h1234.
- Client drives we_n=0 with address 18'h00005 during S_INIT -> after ready, read of 18'h00005 returns the model's preloaded value (write discarded); write_count=0.
- Resetn pulsed low mid write burst -> DQ high-Z and WE_N=1 within the reset cycle, counters=0, SRAM_ready=0 for INIT_CYCLES again; CNT_WIDTH=4 with 20 reads -> read_count holds 15.
